prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 112 +++++++++++
 tb/tb_prog_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Streams program bytes into memory from base_addr for len bytes, with a running checksum.
// Latency: one cycle from byte acceptance to the registered wr_en/wr_addr/wr_data; done pulses with the last write.
// Backpressure: in_ready is high only while a session runs; an in_valid stall holds all state, abort wins over acceptance.
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              accept;
    logic              load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // abort has priority: the byte offered alongside it is dropped
                if (abort) begin
                    state_nxt = IDLE;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (cnt == CNT_ONE) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            cnt      <= '0;
            checksum <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr  <= ptr;
                wr_data  <= in_byte;
                ptr      <= ptr + PTR_ONE;
                cnt      <= cnt - CNT_ONE;
                checksum <= checksum + in_byte;
            end else if (load) begin
                ptr      <= base_addr;
                cnt      <= len;
                checksum <= '0;
            end
        end
    end

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed writes, checksums and handshake flags per step.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] len = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    int n_cmp = 0;
    int n_err = 0;

    prog_loader #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags: {in_ready, busy, done, wr_en}
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {in_ready, busy, done, wr_en}, exp);
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] a, input logic [7:0] d);
        chk(tag, {wr_en, wr_addr, wr_data}, {1'b1, a, d});
    endtask

    initial begin
        // reset state
        #2 rst = 1'b0;
        #1;
        chk_flags("rst_flags", 4'b0000);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_csum", checksum, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_flags("idle_after_rst", 4'b0000);

        // back-to-back session at 0x008
        start = 1'b1; base_addr = 12'h008; len = 13'd3;
        tick();
        start = 1'b0;
        chk_flags("s1_run", 4'b1100);
        chk("s1_csum_clr", checksum, 0);
        in_valid = 1'b1; in_byte = 8'h11;
        tick();
        chk_wr("s1_w0", 12'h008, 8'h11);
        chk_flags("s1_f0", 4'b1101);
        in_byte = 8'h22;
        tick();
        chk_wr("s1_w1", 12'h009, 8'h22);
        in_byte = 8'h33;
        tick();
        chk_wr("s1_w2", 12'h00A, 8'h33);
        chk_flags("s1_done", 4'b0011);
        chk("s1_csum", checksum, 8'h66);
        in_valid = 1'b0;
        tick();
        chk_flags("s1_idle", 4'b0000);
        chk("s1_csum_hold", checksum, 8'h66);

        // wrap at top of memory with gapped in_valid
        start = 1'b1; base_addr = 12'hFFE; len = 13'd4;
        tick();
        start = 1'b0;
        chk_flags("s2_run", 4'b1100);
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            in_byte  = 8'(i / 2 + 1);
            tick();
            if (i % 2 == 0) begin
                chk_wr($sformatf("s2_w%0d", i / 2), 12'(12'hFFE + i / 2), 8'(i / 2 + 1));
            end else begin
                chk_flags($sformatf("s2_stall%0d", i), 4'b1100);
            end
        end
        chk("s2_done", done, 1'b1);
        chk("s2_csum", checksum, 8'h0A);
        in_valid = 1'b0;
        tick();
        chk_flags("s2_idle", 4'b0000);

        // zero-length session
        start = 1'b1; base_addr = 12'h123; len = 13'd0;
        tick();
        start = 1'b0;
        chk_flags("s3_done", 4'b0010);
        tick();
        chk_flags("s3_idle", 4'b0000);

        // abort together with the third byte
        start = 1'b1; base_addr = 12'h100; len = 13'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_byte = 8'hA1;
        tick();
        chk_wr("s4_w0", 12'h100, 8'hA1);
        in_byte = 8'hA2;
        tick();
        chk_wr("s4_w1", 12'h101, 8'hA2);
        abort = 1'b1; in_byte = 8'hA3;
        tick();
        chk_flags("s4_abort", 4'b0000);
        chk("s4_csum", checksum, 8'h43);
        abort = 1'b0; in_valid = 1'b0;
        tick();
        chk_flags("s4_quiet", 4'b0000);

        // new start after abort; restart attempts during RUN are ignored
        start = 1'b1; base_addr = 12'h200; len = 13'd2;
        tick();
        chk_flags("s5_run", 4'b1100);
        chk("s5_csum_clr", checksum, 0);
        base_addr = 12'h300; in_valid = 1'b1; in_byte = 8'h05;
        tick();
        chk_wr("s5_w0", 12'h200, 8'h05);
        base_addr = 12'h400; len = 13'd9; in_valid = 1'b0;
        tick();
        chk_flags("s5_stall", 4'b1100);
        start = 1'b0; in_valid = 1'b1; in_byte = 8'h06;
        tick();
        chk_wr("s5_w1", 12'h201, 8'h06);
        chk("s5_done", done, 1'b1);
        chk("s5_csum", checksum, 8'h0B);
        in_valid = 1'b0; abort = 1'b1;
        tick();
        chk_flags("s5_idle_abort_ignored", 4'b0000);
        abort = 1'b0;

        // asynchronous reset mid-session
        start = 1'b1; base_addr = 12'h050; len = 13'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_byte = 8'h07;
        tick();
        in_byte = 8'h08;
        tick();
        chk_wr("s6_w1", 12'h051, 8'h08);
        #2 rst = 1'b0;
        #1;
        chk_flags("s6_async_flags", 4'b0000);
        chk("s6_async_addr", wr_addr, 0);
        chk("s6_async_data", wr_data, 0);
        chk("s6_async_csum", checksum, 0);
        tick();
        chk_flags("s6_held", 4'b0000);
        rst = 1'b1;
        tick();
        chk_flags("s6_stay_idle", 4'b0000);
        in_valid = 1'b0;
        tick();
        chk("s6_csum_idle", checksum, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
